// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: grants one request at a time,
// drives the memory bus until mem_valid or a stall timeout, then returns a one-cycle response.
module dmem_arbiter #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_data,
  input  logic        mem_valid,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e        state_q;
  logic          owner_q;
  logic          rr_last_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt_q;
  logic          p0_rvalid_q, p1_rvalid_q;
  logic          p0_err_q, p1_err_q;
  logic [31:0]   p0_rdata_q, p1_rdata_q;

  logic          gnt0, gnt1;
  logic          done, timed_out;
  logic [31:0]   rdata_d;

  // Grants are combinational in IDLE and suppressed while reset is asserted.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (p0_req && p1_req) begin
        if (FIXED_PRIO || rr_last_q) gnt0 = 1'b1;
        else                         gnt1 = 1'b1;
      end else begin
        gnt0 = p0_req;
        gnt1 = p1_req;
      end
    end
  end

  assign timed_out = !mem_valid && (cnt_q == CNT_LAST);
  assign done      = (state_q == ACCESS) && (mem_valid || timed_out);
  assign rdata_d   = (mem_valid && !we_q) ? mem_data : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      cnt_q       <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= 32'h0;
      p1_rdata_q  <= 32'h0;
    end else begin
      // NOTE: state uses non-blocking assignments; the defaults below clear the response
      // registers every cycle so they pulse only while in RESP.
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= 32'h0;
      p1_rdata_q  <= 32'h0;
      unique case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            owner_q <= gnt1;
            we_q    <= gnt1 ? p1_we    : p0_we;
            addr_q  <= gnt1 ? p1_addr  : p0_addr;
            wdata_q <= gnt1 ? p1_wdata : p0_wdata;
            cnt_q   <= '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (done) begin
            if (owner_q) begin
              p1_rvalid_q <= 1'b1;
              p1_rdata_q  <= rdata_d;
              p1_err_q    <= timed_out;
            end else begin
              p0_rvalid_q <= 1'b1;
              p0_rdata_q  <= rdata_d;
              p0_err_q    <= timed_out;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (!FIXED_PRIO) rr_last_q <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_err    = p1_err_q;

  assign mem_write = (state_q == ACCESS) && we_q;
  assign mem_addr  = (state_q == ACCESS) ? addr_q  : 32'h0;
  assign mem_wdata = (state_q == ACCESS) ? wdata_q : 32'h0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (round-robin, fixed priority, TIMEOUT=4)
// share the same stimulus; each scenario checks the instance it targets.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] mem_data;
  logic        mem_valid;
  logic        mem_force;
  logic [31:0] mem_force_val;
  logic [31:0] mem_model [256];

  int errors = 0;
  int checks = 0;

  logic a_p0_gnt, a_p0_rvalid, a_p0_err, a_p1_gnt, a_p1_rvalid, a_p1_err, a_mem_write, a_busy;
  logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata;
  logic f_p0_gnt, f_p0_rvalid, f_p0_err, f_p1_gnt, f_p1_rvalid, f_p1_err, f_mem_write, f_busy;
  logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata;
  logic t_p0_gnt, t_p0_rvalid, t_p0_err, t_p1_gnt, t_p1_rvalid, t_p1_err, t_mem_write, t_busy;
  logic [31:0] t_p0_rdata, t_p1_rdata, t_mem_addr, t_mem_wdata;

  dmem_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(a_p0_gnt), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata), .p0_err(a_p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(a_p1_gnt), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata), .p1_err(a_p1_err),
    .mem_addr(a_mem_addr), .mem_write(a_mem_write), .mem_wdata(a_mem_wdata),
    .mem_data(mem_data), .mem_valid(mem_valid), .busy(a_busy)
  );

  dmem_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(16)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata), .p0_err(f_p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata), .p1_err(f_p1_err),
    .mem_addr(f_mem_addr), .mem_write(f_mem_write), .mem_wdata(f_mem_wdata),
    .mem_data(mem_data), .mem_valid(mem_valid), .busy(f_busy)
  );

  dmem_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(t_p0_gnt), .p0_rvalid(t_p0_rvalid), .p0_rdata(t_p0_rdata), .p0_err(t_p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(t_p1_gnt), .p1_rvalid(t_p1_rvalid), .p1_rdata(t_p1_rdata), .p1_err(t_p1_err),
    .mem_addr(t_mem_addr), .mem_write(t_mem_write), .mem_wdata(t_mem_wdata),
    .mem_data(mem_data), .mem_valid(mem_valid), .busy(t_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory behind the round-robin instance; mem_force overrides the read data.
  assign mem_data = mem_force ? mem_force_val : mem_model[a_mem_addr[7:0]];
  always @(posedge clk) begin
    if (a_mem_write && mem_valid) mem_model[a_mem_addr[7:0]] <= a_mem_wdata;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    mem_valid = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    idle_inputs();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cyc();
    idle_inputs();
    p0_req = 1'b1;
    p1_req = 1'b1;
    rst_n  = 1'b0;
    #1;
    checks++;
    if ({a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_mem_write, a_busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_mem_write, a_busy});
    end
    checks++;
    if ({a_mem_addr, a_mem_wdata, a_p0_rdata, a_p1_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rd0=%h rd1=%h expected all 0",
               a_mem_addr, a_mem_wdata, a_p0_rdata, a_p1_rdata);
    end
    cyc();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({a_busy, a_p0_gnt, a_p1_gnt} !== 3'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 000", {a_busy, a_p0_gnt, a_p1_gnt});
    end
  endtask

  task automatic test_store_load();
    do_reset();
    mem_force = 1'b0;
    cyc();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h05; p0_wdata = 32'hDEADBEEF; mem_valid = 1'b1;
    #1;
    checks++;
    if ({a_p0_gnt, a_p1_gnt, a_mem_write} !== 3'b100) begin
      errors++;
      $display("FAIL st_gnt: gnt0,gnt1,mw=%b expected 100", {a_p0_gnt, a_p1_gnt, a_mem_write});
    end
    cyc();
    p0_req = 1'b0;
    #1;
    checks++;
    if (a_mem_write !== 1'b1 || a_mem_addr !== 32'h05 || a_mem_wdata !== 32'hDEADBEEF ||
        a_p0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL st_access: mw=%b addr=%h wdata=%h gnt=%b expected 1 00000005 deadbeef 0",
               a_mem_write, a_mem_addr, a_mem_wdata, a_p0_gnt);
    end
    cyc();
    #1;
    checks++;
    if (a_p0_rvalid !== 1'b1 || a_p0_rdata !== 32'h0 || a_p0_err !== 1'b0 ||
        a_mem_write !== 1'b0 || a_p1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL st_resp: rv=%b rd=%h err=%b mw=%b rv1=%b expected 1 00000000 0 0 0",
               a_p0_rvalid, a_p0_rdata, a_p0_err, a_mem_write, a_p1_rvalid);
    end
    cyc();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h05;
    #1;
    checks++;
    if (a_p0_gnt !== 1'b1 || a_p0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL ld_gnt: gnt=%b rv=%b expected 1 0", a_p0_gnt, a_p0_rvalid);
    end
    cyc();
    p0_req = 1'b0;
    #1;
    checks++;
    if (a_mem_write !== 1'b0 || a_mem_addr !== 32'h05) begin
      errors++;
      $display("FAIL ld_access: mw=%b addr=%h expected 0 00000005", a_mem_write, a_mem_addr);
    end
    cyc();
    #1;
    checks++;
    if (a_p0_rvalid !== 1'b1 || a_p0_rdata !== 32'hDEADBEEF || a_p0_err !== 1'b0) begin
      errors++;
      $display("FAIL ld_resp: rv=%b rd=%h err=%b expected 1 deadbeef 0",
               a_p0_rvalid, a_p0_rdata, a_p0_err);
    end
  endtask

  task automatic test_back_to_back();
    int exp_port;
    do_reset();
    cyc();
    mem_valid = 1'b1;
    mem_force = 1'b1; mem_force_val = 32'h0BAD_F00D;
    p0_req = 1'b1; p0_addr = 32'h10;
    p1_req = 1'b1; p1_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      exp_port = k % 2;
      if (k != 0) cyc();
      #1;
      checks++;
      if (a_p0_gnt !== (exp_port == 0) || a_p1_gnt !== (exp_port == 1)) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: gnt0=%b gnt1=%b expected port %0d", k, a_p0_gnt, a_p1_gnt,
                 exp_port);
      end
      checks++;
      if (f_p0_gnt !== 1'b1 || f_p1_gnt !== 1'b0) begin
        errors++;
        $display("FAIL fp_gnt[%0d]: gnt0=%b gnt1=%b expected 1 0", k, f_p0_gnt, f_p1_gnt);
      end
      cyc();
      #1;
      checks++;
      if ({a_p0_gnt, a_p1_gnt, f_p0_gnt, f_p1_gnt} !== 4'b0) begin
        errors++;
        $display("FAIL rr_nognt[%0d]: got %b expected 0000", k,
                 {a_p0_gnt, a_p1_gnt, f_p0_gnt, f_p1_gnt});
      end
      cyc();
      #1;
      checks++;
      if (a_p0_rvalid !== (exp_port == 0) || a_p1_rvalid !== (exp_port == 1) ||
          f_p0_rvalid !== 1'b1 || f_p1_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rr_resp[%0d]: rv0=%b rv1=%b fp_rv0=%b fp_rv1=%b expected port %0d", k,
                 a_p0_rvalid, a_p1_rvalid, f_p0_rvalid, f_p1_rvalid, exp_port);
      end
    end
    cyc();
    idle_inputs();
    mem_force = 1'b0;
  endtask

  task automatic test_stall();
    int busy_cnt, rv_cnt, rv_at;
    logic wr_seen, er;
    logic [31:0] rd;
    busy_cnt = 0; rv_cnt = 0; rv_at = -1; wr_seen = 1'b0; er = 1'b1; rd = 32'h0;
    do_reset();
    cyc();
    mem_force = 1'b1; mem_force_val = 32'hCAFE0007;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h07; mem_valid = 1'b0;
    #1;
    checks++;
    if (a_p1_gnt !== 1'b1 || a_p0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL stall_gnt: gnt1=%b gnt0=%b expected 1 0", a_p1_gnt, a_p0_gnt);
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      p1_req = 1'b0;
      mem_valid = (i == 3);
      #1;
      if (a_busy) busy_cnt++;
      if (a_mem_write) wr_seen = 1'b1;
      if (a_p1_rvalid) begin
        rv_cnt++; rv_at = i; rd = a_p1_rdata; er = a_p1_err;
      end
    end
    mem_valid = 1'b0;
    checks++;
    if (busy_cnt != 5) begin
      errors++;
      $display("FAIL stall_busy: busy cycles %0d expected 5", busy_cnt);
    end
    checks++;
    if (rv_cnt != 1 || rv_at != 4) begin
      errors++;
      $display("FAIL stall_rvalid: count %0d at %0d expected 1 at 4", rv_cnt, rv_at);
    end
    checks++;
    if (rd !== 32'hCAFE0007 || er !== 1'b0 || wr_seen !== 1'b0) begin
      errors++;
      $display("FAIL stall_data: rd=%h err=%b wr=%b expected cafe0007 0 0", rd, er, wr_seen);
    end
    mem_force = 1'b0;
  endtask

  task automatic test_timeout();
    int acc_cnt, rv_at;
    logic er;
    logic [31:0] rd;
    for (int pass = 0; pass < 2; pass++) begin
      acc_cnt = 0; rv_at = -1; er = 1'bx; rd = 32'hx;
      do_reset();
      cyc();
      mem_force = 1'b1; mem_force_val = 32'h5555AAAA;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h02; mem_valid = 1'b0;
      #1;
      checks++;
      if (t_p0_gnt !== 1'b1) begin
        errors++;
        $display("FAIL to_gnt[%0d]: gnt=%b expected 1", pass, t_p0_gnt);
      end
      for (int i = 0; i < 8; i++) begin
        cyc();
        p0_req = 1'b0;
        mem_valid = (pass == 1) && (i == 3);
        #1;
        if (t_busy && !t_p0_rvalid) acc_cnt++;
        if (t_p0_rvalid) begin
          rv_at = i; rd = t_p0_rdata; er = t_p0_err;
        end
      end
      mem_valid = 1'b0;
      checks++;
      if (acc_cnt != 4 || rv_at != 4) begin
        errors++;
        $display("FAIL to_len[%0d]: access %0d rvalid at %0d expected 4 at 4", pass, acc_cnt,
                 rv_at);
      end
      checks++;
      if (pass == 0 && (er !== 1'b1 || rd !== 32'h0)) begin
        errors++;
        $display("FAIL to_abort: err=%b rd=%h expected 1 00000000", er, rd);
      end else if (pass == 1 && (er !== 1'b0 || rd !== 32'h5555AAAA)) begin
        errors++;
        $display("FAIL to_last_ok: err=%b rd=%h expected 0 5555aaaa", er, rd);
      end
    end
    mem_force = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_force = 1'b0;
    cyc();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h09; p0_wdata = 32'h11112222; mem_valid = 1'b0;
    #1;
    checks++;
    if (a_p0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rm_gnt: gnt=%b expected 1", a_p0_gnt);
    end
    cyc();
    p0_req = 1'b0;
    #1;
    checks++;
    if (a_mem_write !== 1'b1) begin
      errors++;
      $display("FAIL rm_write: mw=%b expected 1", a_mem_write);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_mem_write, a_busy, a_p0_rvalid, a_p0_err} !== 4'b0 ||
        a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rm_abort: mw,busy,rv,err=%b addr=%h wdata=%h expected 0000 0 0",
               {a_mem_write, a_busy, a_p0_rvalid, a_p0_err}, a_mem_addr, a_mem_wdata);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      checks++;
      if (a_p0_rvalid !== 1'b0 || a_p0_err !== 1'b0) begin
        errors++;
        $display("FAIL rm_quiet[%0d]: rv=%b err=%b expected 0 0", i, a_p0_rvalid, a_p0_err);
      end
    end
    cyc();
    rst_n = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h30;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h31;
    mem_valid = 1'b1;
    #1;
    checks++;
    if (a_p0_gnt !== 1'b1 || a_p1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rm_first: gnt0=%b gnt1=%b expected 1 0", a_p0_gnt, a_p1_gnt);
    end
    cyc();
    idle_inputs();
    cyc();
    cyc();
  endtask

  task automatic test_wait_during_access();
    do_reset();
    mem_force = 1'b0;
    cyc();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h05; mem_valid = 1'b0;
    #1;
    checks++;
    if (a_p0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL wt_gnt0: gnt=%b expected 1", a_p0_gnt);
    end
    cyc();
    p0_req = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h06;
    #1;
    checks++;
    if (a_p1_gnt !== 1'b0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL wt_access1: gnt1=%b busy=%b expected 0 1", a_p1_gnt, a_busy);
    end
    cyc();
    mem_valid = 1'b1;
    #1;
    checks++;
    if (a_p1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL wt_access2: gnt1=%b expected 0", a_p1_gnt);
    end
    cyc();
    #1;
    checks++;
    if (a_p1_gnt !== 1'b0 || a_p0_rvalid !== 1'b1 || a_p0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wt_resp: gnt1=%b rv0=%b rd0=%h expected 0 1 deadbeef",
               a_p1_gnt, a_p0_rvalid, a_p0_rdata);
    end
    cyc();
    #1;
    checks++;
    if (a_p1_gnt !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL wt_gnt1: gnt1=%b busy=%b expected 1 0", a_p1_gnt, a_busy);
    end
    cyc();
    p1_req = 1'b0;
    cyc();
    #1;
    checks++;
    if (a_p1_rvalid !== 1'b1 || a_p0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL wt_resp1: rv1=%b rv0=%b expected 1 0", a_p1_rvalid, a_p0_rvalid);
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_force = 1'b0;
    mem_force_val = 32'h0;
    idle_inputs();
    test_reset();
    test_store_load();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_wait_during_access();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
